// File: rtl/instruction_execute_if.sv
// DX -> EX -> XM pipeline bundle for the MIPS execute stage.
// The EX stage uses the slave view: it consumes DX_* and produces stall and XM_*.
interface instruction_execute_if #(parameter int WIDTH = 32);
  logic             DX_MemtoReg;
  logic             DX_RegWrite;
  logic             DX_MemRead;
  logic             DX_MemWrite;
  logic             DX_branch;
  logic             DX_jump;
  logic [2:0]       DX_ALUctr;
  logic [WIDTH-1:0] DX_JT;
  logic [WIDTH-1:0] DX_NPC;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [15:0]      DX_imm;
  logic [4:0]       DX_RD;
  logic [4:0]       DX_MD;
  logic             stall;
  logic             XM_MemtoReg;
  logic             XM_RegWrite;
  logic             XM_MemRead;
  logic             XM_MemWrite;
  logic [WIDTH-1:0] XM_ALUout;
  logic [4:0]       XM_RD;
  logic [4:0]       XM_MD;
  logic             XM_redirect;
  logic [WIDTH-1:0] XM_target;

  modport master (
    output DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_branch, DX_jump,
    output DX_ALUctr, DX_JT, DX_NPC, A, B, DX_imm, DX_RD, DX_MD,
    input  stall, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite,
    input  XM_ALUout, XM_RD, XM_MD, XM_redirect, XM_target
  );

  modport slave (
    input  DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_branch, DX_jump,
    input  DX_ALUctr, DX_JT, DX_NPC, A, B, DX_imm, DX_RD, DX_MD,
    output stall, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite,
    output XM_ALUout, XM_RD, XM_MD, XM_redirect, XM_target
  );
endinterface

// File: rtl/instruction_execute.sv
// MIPS EX stage: single-cycle ALU and branch/jump resolution into XM, plus an
// iterative shift-add multiply (ALUctr=7) that stalls upstream for WIDTH cycles.
module instruction_execute #(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  instruction_execute_if.slave  ex
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] diff_s, alu_s, target_s, acc_s;
  logic [WIDTH-1:0] acc_r, mcand_r, mplier_r;
  logic [CW-1:0]    cnt_r;
  logic             zero_s, redirect_s, is_mul_s, last_s;
  logic             m_memtoreg_r, m_regwrite_r, m_memread_r, m_memwrite_r;
  logic [4:0]       m_rd_r, m_md_r;

  assign is_mul_s = (ex.DX_ALUctr == 3'd7);
  assign last_s   = (cnt_r == CW'(WIDTH - 1));
  assign ex.stall = (state_r == ST_BUSY);

  // ALU result, branch condition, redirect target and next multiply partial sum
  always_comb begin
    diff_s = ex.A - ex.B;
    zero_s = (diff_s == {WIDTH{1'b0}});
    case (ex.DX_ALUctr)
      3'd0:       alu_s = ex.A + ex.B;
      3'd1, 3'd5: alu_s = diff_s;
      3'd2:       alu_s = ex.A & ex.B;
      3'd3:       alu_s = ex.A | ex.B;
      3'd4:       alu_s = {{(WIDTH-1){1'b0}}, ($signed(ex.A) < $signed(ex.B))};
      3'd6:       alu_s = ex.A ^ ex.B;
      default:    alu_s = {WIDTH{1'b0}};
    endcase
    redirect_s = ex.DX_jump | (ex.DX_branch & zero_s);
    if (ex.DX_jump) begin
      target_s = ex.DX_JT;
    end else begin
      target_s = ex.DX_NPC + {{(WIDTH-18){ex.DX_imm[15]}}, ex.DX_imm, 2'b00};
    end
    acc_s = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: enter BUSY on a mul, leave after the last multiplier bit
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (is_mul_s) state_s = ST_BUSY;
        else          state_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (last_s) state_s = ST_IDLE;
        else        state_s = ST_BUSY;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // XM pipeline register and multiplier datapath; XM defaults to a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex.XM_MemtoReg <= 1'b0;
      ex.XM_RegWrite <= 1'b0;
      ex.XM_MemRead  <= 1'b0;
      ex.XM_MemWrite <= 1'b0;
      ex.XM_ALUout   <= {WIDTH{1'b0}};
      ex.XM_RD       <= 5'd0;
      ex.XM_MD       <= 5'd0;
      ex.XM_redirect <= 1'b0;
      ex.XM_target   <= {WIDTH{1'b0}};
      acc_r          <= {WIDTH{1'b0}};
      mcand_r        <= {WIDTH{1'b0}};
      mplier_r       <= {WIDTH{1'b0}};
      cnt_r          <= {CW{1'b0}};
      m_memtoreg_r   <= 1'b0;
      m_regwrite_r   <= 1'b0;
      m_memread_r    <= 1'b0;
      m_memwrite_r   <= 1'b0;
      m_rd_r         <= 5'd0;
      m_md_r         <= 5'd0;
    end else begin
      ex.XM_MemtoReg <= 1'b0;
      ex.XM_RegWrite <= 1'b0;
      ex.XM_MemRead  <= 1'b0;
      ex.XM_MemWrite <= 1'b0;
      ex.XM_ALUout   <= {WIDTH{1'b0}};
      ex.XM_RD       <= 5'd0;
      ex.XM_MD       <= 5'd0;
      ex.XM_redirect <= 1'b0;
      ex.XM_target   <= {WIDTH{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (is_mul_s) begin
            mcand_r      <= ex.A;
            mplier_r     <= ex.B;
            acc_r        <= {WIDTH{1'b0}};
            cnt_r        <= {CW{1'b0}};
            m_memtoreg_r <= ex.DX_MemtoReg;
            m_regwrite_r <= ex.DX_RegWrite;
            m_memread_r  <= ex.DX_MemRead;
            m_memwrite_r <= ex.DX_MemWrite;
            m_rd_r       <= ex.DX_RD;
            m_md_r       <= ex.DX_MD;
          end else begin
            ex.XM_MemtoReg <= ex.DX_MemtoReg;
            ex.XM_RegWrite <= ex.DX_RegWrite;
            ex.XM_MemRead  <= ex.DX_MemRead;
            ex.XM_MemWrite <= ex.DX_MemWrite;
            ex.XM_ALUout   <= alu_s;
            ex.XM_RD       <= ex.DX_RD;
            ex.XM_MD       <= ex.DX_MD;
            ex.XM_redirect <= redirect_s;
            ex.XM_target   <= target_s;
          end
        end
        ST_BUSY: begin
          acc_r    <= acc_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) begin
            ex.XM_MemtoReg <= m_memtoreg_r;
            ex.XM_RegWrite <= m_regwrite_r;
            ex.XM_MemRead  <= m_memread_r;
            ex.XM_MemWrite <= m_memwrite_r;
            ex.XM_ALUout   <= acc_s;
            ex.XM_RD       <= m_rd_r;
            ex.XM_MD       <= m_md_r;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_execute.sv
// Self-checking bench for instruction_execute: directed spec cases plus randomized
// ALU/branch/mul traffic checked against a plain-arithmetic reference model.
module tb_instruction_execute;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instruction_execute_if #(.WIDTH(32)) bus ();

  instruction_execute #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] ctr, input logic [31:0] a, input logic [31:0] b);
    case (ctr)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5:    return a - b;
      3'd6:    return a ^ b;
      default: return 32'(64'(a) * 64'(b));
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic jp, input logic [31:0] jt,
                                            input logic [31:0] npc, input logic [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return jp ? jt : npc + 32'(off);
  endfunction

  task automatic drive(input logic [2:0] ctr, input logic [31:0] a, input logic [31:0] b,
                       input logic br, input logic jp, input logic [31:0] jt, input logic [31:0] npc,
                       input logic [15:0] imm, input logic [4:0] rd, input logic [4:0] md,
                       input logic [3:0] ctl);
    bus.DX_ALUctr = ctr;   bus.A = a;        bus.B = b;
    bus.DX_branch = br;    bus.DX_jump = jp; bus.DX_JT = jt;
    bus.DX_NPC = npc;      bus.DX_imm = imm; bus.DX_RD = rd; bus.DX_MD = md;
    {bus.DX_MemtoReg, bus.DX_RegWrite, bus.DX_MemRead, bus.DX_MemWrite} = ctl;
  endtask

  task automatic drive_random_nonmul();
    drive(3'($urandom_range(0, 6)), $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom,
          $urandom, 16'($urandom), 5'($urandom), 5'($urandom), 4'($urandom));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0, 5'd0, 5'd0, 4'd0);
    rst = 1'b1;
    step();
    step();
    total++;
    if ({bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead, bus.XM_MemWrite, bus.XM_ALUout,
         bus.XM_RD, bus.XM_MD, bus.XM_redirect, bus.XM_target} !== 81'd0) begin
      bad++; $display("FAIL reset_xm: got ALUout=%h RD=%0d redirect=%b, want all zero",
                      bus.XM_ALUout, bus.XM_RD, bus.XM_redirect);
    end
    total++;
    if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu_directed();
    drive(3'd0, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0, 5'd3, 5'd0, 4'b0100);
    step();
    total++;
    if ({bus.XM_ALUout, bus.XM_RD, bus.XM_RegWrite, bus.XM_redirect} !== {32'd12, 5'd3, 1'b1, 1'b0}) begin
      bad++; $display("FAIL add_5_7: got out=%0d rd=%0d rw=%b redir=%b want 12 3 1 0",
                      bus.XM_ALUout, bus.XM_RD, bus.XM_RegWrite, bus.XM_redirect);
    end
    drive(3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0, 5'd4, 5'd0, 4'b0100);
    step();
    total++;
    if (bus.XM_ALUout !== 32'd1) begin bad++; $display("FAIL slt_neg: got %h want 1", bus.XM_ALUout); end
    bus.DX_ALUctr = 3'd1;
    step();
    total++;
    if (bus.XM_ALUout !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL sub_wrap: got %h want fffffffe", bus.XM_ALUout);
    end
  endtask

  task automatic test_branch_jump();
    drive(3'd5, 32'd9, 32'd9, 1'b1, 1'b0, 32'd0, 32'h100, 16'hFFFE, 5'd0, 5'd0, 4'd0);
    step();
    total++;
    if ({bus.XM_redirect, bus.XM_target} !== {1'b1, 32'h0000_00F8}) begin
      bad++; $display("FAIL beq_taken: got redir=%b tgt=%h want 1 000000f8", bus.XM_redirect, bus.XM_target);
    end
    bus.B = 32'd10;
    step();
    total++;
    if (bus.XM_redirect !== 1'b0) begin bad++; $display("FAIL beq_not_taken: got %b want 0", bus.XM_redirect); end
    drive(3'd0, 32'd1, 32'd2, 1'b0, 1'b1, 32'h400, 32'h100, 16'h0010, 5'd0, 5'd0, 4'd0);
    step();
    total++;
    if ({bus.XM_redirect, bus.XM_target} !== {1'b1, 32'h400}) begin
      bad++; $display("FAIL jump: got redir=%b tgt=%h want 1 00000400", bus.XM_redirect, bus.XM_target);
    end
    drive(3'd5, 32'd7, 32'd7, 1'b1, 1'b1, 32'h800, 32'h100, 16'h0010, 5'd0, 5'd0, 4'd0);
    step();
    total++;
    if ({bus.XM_redirect, bus.XM_target} !== {1'b1, 32'h800}) begin
      bad++; $display("FAIL jump_priority: got redir=%b tgt=%h want 1 00000800", bus.XM_redirect, bus.XM_target);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_out, exp_tgt;
    logic        exp_redir;
    logic [13:0] exp_ctl;
    for (int i = 0; i < 60; i++) begin
      drive_random_nonmul();
      if ($urandom_range(0, 3) == 0) bus.B = bus.A;
      exp_out   = ref_alu(bus.DX_ALUctr, bus.A, bus.B);
      exp_redir = bus.DX_jump | (bus.DX_branch & (bus.A == bus.B));
      exp_tgt   = ref_target(bus.DX_jump, bus.DX_JT, bus.DX_NPC, bus.DX_imm);
      exp_ctl   = {bus.DX_MemtoReg, bus.DX_RegWrite, bus.DX_MemRead, bus.DX_MemWrite, bus.DX_RD, bus.DX_MD};
      step();
      total++;
      if (bus.XM_ALUout !== exp_out) begin
        bad++; $display("FAIL rand_alu[%0d]: got %h want %h", i, bus.XM_ALUout, exp_out);
      end
      total++;
      if ({bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead, bus.XM_MemWrite, bus.XM_RD, bus.XM_MD} !== exp_ctl) begin
        bad++; $display("FAIL rand_ctl[%0d]: got rd=%0d md=%0d want ctl %h", i, bus.XM_RD, bus.XM_MD, exp_ctl);
      end
      total++;
      if (bus.XM_redirect !== exp_redir || (exp_redir && bus.XM_target !== exp_tgt)) begin
        bad++; $display("FAIL rand_redirect[%0d]: got %b/%h want %b/%h", i, bus.XM_redirect,
                        bus.XM_target, exp_redir, exp_tgt);
      end
    end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int          cycles;
    logic [31:0] exp_out;
    exp_out = ref_alu(3'd7, a, b);
    drive(3'd7, a, b, 1'b1, 1'b1, 32'h1234, 32'h0, 16'd0, rd, 5'd6, 4'b0100);
    step();
    cycles = 0;
    while (bus.stall === 1'b1 && cycles < 40) begin
      total++;
      if ({bus.XM_RegWrite, bus.XM_MemRead, bus.XM_MemWrite, bus.XM_MemtoReg, bus.XM_redirect} !== 5'd0) begin
        bad++; $display("FAIL mul_bubble: cycle %0d controls not a bubble", cycles);
      end
      drive_random_nonmul();
      cycles++;
      step();
    end
    total++;
    if (cycles != 32) begin bad++; $display("FAIL mul_stall_len: got %0d cycles want 32", cycles); end
    total++;
    if ({bus.XM_ALUout, bus.XM_RD, bus.XM_MD, bus.XM_RegWrite, bus.XM_redirect} !== {exp_out, rd, 5'd6, 1'b1, 1'b0}) begin
      bad++; $display("FAIL mul_result: got %h rd=%0d rw=%b redir=%b want %h rd=%0d rw=1 redir=0",
                      bus.XM_ALUout, bus.XM_RD, bus.XM_RegWrite, bus.XM_redirect, exp_out, rd);
    end
  endtask

  task automatic test_mul();
    run_mul(32'd1000, 32'd3000, 5'd8);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    for (int i = 0; i < 3; i++) run_mul($urandom, $urandom, 5'($urandom_range(1, 31)));
    drive(3'd0, 32'd40, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0, 5'd2, 5'd0, 4'b0100);
    step();
    total++;
    if (bus.XM_ALUout !== 32'd42) begin bad++; $display("FAIL add_after_mul: got %0d want 42", bus.XM_ALUout); end
  endtask

  task automatic test_reset_mid_mul();
    drive(3'd7, 32'd123, 32'd456, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0, 5'd5, 5'd0, 4'b0100);
    step();
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0, 5'd0, 5'd0, 4'd0);
    repeat (9) step();
    total++;
    if (bus.stall !== 1'b1) begin bad++; $display("FAIL mid_mul_busy: got stall %b want 1", bus.stall); end
    rst = 1'b1;
    #1;
    total++;
    if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_mid_mul_stall: got %b want 0", bus.stall); end
    total++;
    if ({bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead, bus.XM_MemWrite, bus.XM_ALUout,
         bus.XM_RD, bus.XM_MD, bus.XM_redirect, bus.XM_target} !== 81'd0) begin
      bad++; $display("FAIL rst_mid_mul_xm: got ALUout=%h RD=%0d want all zero", bus.XM_ALUout, bus.XM_RD);
    end
    step();
    rst = 1'b0;
    drive(3'd0, 32'd100, 32'd23, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0, 5'd7, 5'd0, 4'b0100);
    step();
    total++;
    if ({bus.XM_ALUout, bus.XM_RD, bus.XM_RegWrite, bus.stall} !== {32'd123, 5'd7, 1'b1, 1'b0}) begin
      bad++; $display("FAIL add_after_rst: got %0d rd=%0d stall=%b want 123 rd=7 stall=0",
                      bus.XM_ALUout, bus.XM_RD, bus.stall);
    end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_branch_jump();
    test_back_to_back();
    test_mul();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
